// File: rtl/mips_pkg.sv
// Shared datapath widths and writeback requester identifiers for the register-file write port.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int GID_W      = 2;

  typedef enum logic [GID_W-1:0] {
    REQ_ALU    = 2'd0,
    REQ_LOAD   = 2'd1,
    REQ_MULDIV = 2'd2
  } req_id_e;

endpackage

// File: rtl/wb_age_counter.sv
// Saturating aging counter for one writeback requester: counts consecutive lost cycles and
// flags the requester as starved once the limit is reached.
module wb_age_counter #(
  parameter int CW    = 3,
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  output logic o_starved
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count != CW'(LIMIT)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_starved = (r_count == CW'(LIMIT));

endmodule

// File: rtl/wb_port_arbiter.sv
// Fixed-priority writeback arbiter with starvation aging; owns the registered register-file
// write port and silently drops writes to $0.
module wb_port_arbiter
  import mips_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*REG_ADDR_W-1:0]   req_dest,
  input  logic [N_REQ*DATA_W-1:0]       req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          regwrite,
  output logic [REG_ADDR_W-1:0]         dest,
  output logic [DATA_W-1:0]             write_back,
  output logic [GID_W-1:0]              grant_id,
  output logic                          wb_stall
);

  logic [REG_ADDR_W-1:0] w_dest_arr [N_REQ];
  logic [DATA_W-1:0]     w_data_arr [N_REQ];
  logic [N_REQ-1:0]      w_aged;
  logic [N_REQ-1:0]      w_starved;
  logic [N_REQ-1:0]      w_pool;
  logic [N_REQ-1:0]      w_clear;
  logic [N_REQ-1:0]      w_grant;
  logic [GID_W-1:0]      w_gnt_idx;
  logic                  w_gnt_any;
  logic [REG_ADDR_W-1:0] w_sel_dest;
  logic [DATA_W-1:0]     w_sel_data;

  logic                  r_regwrite;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [DATA_W-1:0]     r_write_back;
  logic [GID_W-1:0]      r_grant_id;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_dest_arr[gi] = req_dest[REG_ADDR_W*gi +: REG_ADDR_W];
      assign w_data_arr[gi] = req_data[DATA_W*gi +: DATA_W];
      assign w_clear[gi]    = flush | ~req_valid[gi] | w_grant[gi];

      wb_age_counter #(
        .CW    (CW),
        .LIMIT (STARVE_LIMIT)
      ) u_age (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_clear[gi]),
        .o_starved (w_aged[gi])
      );
    end
  endgenerate

  // Starved requesters preempt everyone else; within either pool the lowest index wins.
  assign w_starved = w_aged & req_valid;
  assign w_pool    = (|w_starved) ? w_starved : req_valid;

  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    if (!flush) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (w_pool[i]) begin
          w_gnt_idx = GID_W'(i);
          w_gnt_any = 1'b1;
        end
      end
      if (w_gnt_any) begin
        w_grant[w_gnt_idx] = 1'b1;
      end
    end
  end

  assign w_sel_dest = w_dest_arr[w_gnt_idx];
  assign w_sel_data = w_data_arr[w_gnt_idx];

  // A $0 write is still consumed, but leaves the write port contents untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_regwrite   <= 1'b0;
      r_dest       <= '0;
      r_write_back <= '0;
      r_grant_id   <= '0;
    end else begin
      r_regwrite <= 1'b0;
      if (w_gnt_any) begin
        r_grant_id <= w_gnt_idx;
        if (w_sel_dest != '0) begin
          r_regwrite   <= 1'b1;
          r_dest       <= w_sel_dest;
          r_write_back <= w_sel_data;
        end
      end
    end
  end

  assign req_ready  = w_grant;
  assign regwrite   = r_regwrite;
  assign dest       = r_dest;
  assign write_back = r_write_back;
  assign grant_id   = r_grant_id;
  assign wb_stall   = |(req_valid & ~w_grant);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a rule-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic honouring the hold rule.
module tb_wb_port_arbiter;
  import mips_pkg::*;

  localparam int N   = 3;
  localparam int LIM = 4;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        flush     = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [14:0] req_dest  = '0;
  logic [95:0] req_data  = '0;
  logic [2:0]  req_ready;
  logic        regwrite;
  logic [4:0]  dest;
  logic [31:0] write_back;
  logic [1:0]  grant_id;
  logic        wb_stall;

  wb_port_arbiter #(
    .N_REQ        (N),
    .STARVE_LIMIT (LIM),
    .CW           (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_dest   (req_dest),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .regwrite   (regwrite),
    .dest       (dest),
    .write_back (write_back),
    .grant_id   (grant_id),
    .wb_stall   (wb_stall)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          m_age [N];
  logic        m_regwrite;
  logic [4:0]  m_dest;
  logic [31:0] m_wb;
  logic [1:0]  m_gid;
  int          last_w;
  logic [2:0]  s_ready;
  int          grant_log [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_age[i] = 0;
    m_regwrite = 1'b0;
    m_dest     = '0;
    m_wb       = '0;
    m_gid      = '0;
  endtask

  // Winner from the arbitration rules: starved requesters first, then any valid one, lowest index.
  function automatic int model_winner();
    int starved [$];
    int valid_q [$];
    if (flush) return -1;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i]) begin
        valid_q.push_back(i);
        if (m_age[i] == LIM) starved.push_back(i);
      end
    end
    if (starved.size() > 0) return starved[0];
    if (valid_q.size() > 0) return valid_q[0];
    return -1;
  endfunction

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int         w;
    logic [2:0] e_ready;
    logic       e_stall;
    logic [4:0] d;
    @(negedge clk);
    w       = model_winner();
    e_ready = '0;
    e_stall = 1'b0;
    if (w >= 0) e_ready[w] = 1'b1;
    for (int i = 0; i < N; i++) if (req_valid[i] && i != w) e_stall = 1'b1;
    s_ready = req_ready;
    check("req_ready",  32'(req_ready),  32'(e_ready));
    check("wb_stall",   32'(wb_stall),   32'(e_stall));
    check("regwrite",   32'(regwrite),   32'(m_regwrite));
    check("dest",       32'(dest),       32'(m_dest));
    check("write_back", write_back,      m_wb);
    check("grant_id",   32'(grant_id),   32'(m_gid));
    $display("cyc %0d rst_n=%b flush=%b valid=%b grant=%0d regwrite=%b dest=%0d wb=%h",
             cyc, reset_n, flush, req_valid, w, regwrite, dest, write_back);
    @(posedge clk);
    cyc++;
    last_w = w;
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (flush || !req_valid[i] || w == i) m_age[i] = 0;
        else if (m_age[i] < LIM) m_age[i] = m_age[i] + 1;
      end
      m_regwrite = 1'b0;
      if (w >= 0) begin
        m_gid = 2'(w);
        d = req_dest[5*w +: 5];
        if (d != 5'd0) begin
          m_regwrite = 1'b1;
          m_dest     = d;
          m_wb       = req_data[32*w +: 32];
        end
      end
      grant_log.push_back(w);
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] d, input logic [31:0] x);
    req_valid[i]        = v;
    req_dest[5*i +: 5]  = d;
    req_data[32*i +: 32] = x;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    last_w = -1;

    // Reset state
    repeat (2) cycle();
    check("rst regwrite",   32'(regwrite),  32'd0);
    check("rst dest",       32'(dest),      32'd0);
    check("rst write_back", write_back,     32'd0);
    check("rst req_ready",  32'(s_ready),   32'd0);
    reset_n = 1'b1;
    cycle();

    // Single LOAD request
    set_req(REQ_LOAD, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle();
    check("single ready",      32'(s_ready),  32'b010);
    check("single regwrite",   32'(regwrite), 32'd1);
    check("single dest",       32'(dest),     32'd5);
    check("single write_back", write_back,    32'hDEADBEEF);
    check("single grant_id",   32'(grant_id), 32'd1);
    set_req(REQ_LOAD, 1'b0, 5'd0, 32'd0);
    cycle();

    // Aging with all three requesters continuously valid
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'(32'h100 + i));
    grant_log.delete();
    repeat (12) begin
      cycle();
      check("aging stall", 32'(wb_stall), 32'd1);
    end
    check("aging g0", 32'(grant_log[0]), 32'd0);
    check("aging g1", 32'(grant_log[1]), 32'd0);
    check("aging g2", 32'(grant_log[2]), 32'd0);
    check("aging g3", 32'(grant_log[3]), 32'd0);
    check("aging g4", 32'(grant_log[4]), 32'd1);
    check("aging g5", 32'(grant_log[5]), 32'd2);
    req_valid = '0;
    cycle();

    // Write to $0 is consumed but does not disturb the port
    set_req(0, 1'b1, 5'd9, 32'h0000AAAA);
    cycle();
    set_req(0, 1'b1, 5'd0, 32'h00001234);
    cycle();
    check("r0 ready",      32'(s_ready),  32'b001);
    check("r0 regwrite",   32'(regwrite), 32'd0);
    check("r0 dest",       32'(dest),     32'd9);
    check("r0 write_back", write_back,    32'h0000AAAA);
    req_valid = '0;
    cycle();

    // Same destination from two requesters: serialized, later grant's data lands last
    set_req(0, 1'b1, 5'd4, 32'h0000000A);
    set_req(1, 1'b1, 5'd4, 32'h0000000B);
    cycle();
    check("samedst first", write_back, 32'h0000000A);
    set_req(0, 1'b0, 5'd0, 32'd0);
    cycle();
    check("samedst dest",  32'(dest),  32'd4);
    check("samedst final", write_back, 32'h0000000B);
    req_valid = '0;
    cycle();

    // Flush clears ready and aging
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 10), 32'(32'h200 + i));
    repeat (2) cycle();
    flush = 1'b1;
    cycle();
    check("flush ready", 32'(s_ready), 32'd0);
    flush = 1'b0;
    grant_log.delete();
    repeat (5) cycle();
    check("flush g0", 32'(grant_log[0]), 32'd0);
    check("flush g1", 32'(grant_log[1]), 32'd0);
    check("flush g2", 32'(grant_log[2]), 32'd0);
    check("flush g3", 32'(grant_log[3]), 32'd0);
    check("flush g4", 32'(grant_log[4]), 32'd1);
    req_valid = '0;
    cycle();

    // Asynchronous reset between edges discards the pending write
    set_req(1, 1'b1, 5'd7, 32'h77777777);
    cycle();
    set_req(1, 1'b0, 5'd0, 32'd0);
    set_req(0, 1'b1, 5'd9, 32'h99999999);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("arst regwrite",   32'(regwrite), 32'd0);
    check("arst dest",       32'(dest),     32'd0);
    check("arst write_back", write_back,    32'd0);
    check("arst grant_id",   32'(grant_id), 32'd0);
    cycle();
    check("arst discard", 32'(regwrite), 32'd0);
    reset_n = 1'b1;
    set_req(0, 1'b0, 5'd0, 32'd0);
    set_req(1, 1'b1, 5'd3, 32'h31313131);
    set_req(2, 1'b1, 5'd6, 32'h62626262);
    cycle();
    check("arst first ready", 32'(s_ready),  32'b010);
    check("arst first gid",   32'(grant_id), 32'd1);
    check("arst first data",  write_back,    32'h31313131);
    req_valid = '0;
    cycle();

    // Randomized traffic; a pending request keeps dest/data until granted
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && last_w != i)) begin
          set_req(i, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
        end
      end
      flush = ($urandom_range(0, 7) == 0);
      cycle();
    end
    flush     = 1'b0;
    req_valid = '0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
